// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants, frame field lengths and FSM state type for the boot loader
package imem_loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int ADDR_LEN = 4;
    localparam int CNT_LEN = 2;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: shifts bytes in MSB first and flags the byte that completes a 32-bit word
module imem_word_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);
    logic [23:0] r_word;
    logic [1:0]  r_cnt;
    assign o_word = {r_word, i_byte};
    assign o_full = i_push && (r_cnt == 2'd3);
    // accumulate the first three bytes; the fourth is merged combinationally into o_word
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_push) begin
            r_word <= {r_word[15:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing big-endian words to instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_in_data,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_range,
    output logic        o_err_csum
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = S_CSUM;
`else
    localparam state_t TAIL = S_DONE;
`endif
    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_base;
    logic [15:0] r_count;
    logic [15:0] r_idx;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err_range;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic        r_err_csum;
`endif
    logic        w_accept;
    logic        w_sync;
    logic        w_push;
    logic        w_full;
    logic        w_last_word;
    logic        w_out_range;
    logic [31:0] w_word;
    logic [31:0] w_addr;
    logic [15:0] w_count;

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_sync      = w_accept && (r_state == S_IDLE) && (i_in_data == SYNC_BYTE);
    assign w_push      = w_accept && (r_state == S_DATA);
    assign w_addr      = r_base + {14'd0, r_idx, 2'b00};
    assign w_out_range = ({1'b0, w_addr} + 33'd3) >= 33'(MEM_BYTES);
    assign w_last_word = r_idx == (r_count - 16'd1);
    assign w_count     = {r_count[7:0], i_in_data};

    imem_word_packer u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_sync),
        .i_push  (w_push),
        .i_byte  (i_in_data),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    // frame parser: header collection, word writes with range suppression, completion pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_err_range <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_err_csum  <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_sync) begin
                    r_state     <= S_ADDR;
                    r_byte_cnt  <= '0;
                    r_cpu_hold  <= 1'b1;
                    r_err_range <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum       <= '0;
                    r_err_csum  <= 1'b0;
`endif
                end
                S_ADDR: if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum <= r_sum + i_in_data;
`endif
                    if (r_byte_cnt == 2'(ADDR_LEN - 1)) begin
                        r_base     <= {r_base[23:0], i_in_data[7:2], 2'b00};
                        r_byte_cnt <= '0;
                        r_state    <= S_CNT;
                    end else begin
                        r_base     <= {r_base[23:0], i_in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_CNT: if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum <= r_sum + i_in_data;
`endif
                    r_count <= w_count;
                    if (r_byte_cnt == 2'(CNT_LEN - 1)) begin
                        r_byte_cnt <= '0;
                        r_idx      <= '0;
                        r_state    <= (w_count == 16'd0) ? TAIL : S_DATA;
                        r_done     <= (w_count == 16'd0) && (TAIL == S_DONE);
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_DATA: if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum <= r_sum + i_in_data;
`endif
                    if (w_full) begin
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_word;
                        r_mem_we    <= !w_out_range;
                        r_err_range <= r_err_range || w_out_range;
                        r_idx       <= r_idx + 16'd1;
                        if (w_last_word) begin
                            r_state <= TAIL;
                            r_done  <= TAIL == S_DONE;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: if (w_accept) begin
                    r_err_csum <= r_err_csum || (8'(r_sum + i_in_data) != 8'd0);
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                end
`endif
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_cpu_hold <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_state != S_DONE;
    assign o_busy      = r_state != S_IDLE;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_err_range = r_err_range;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign o_err_csum  = r_err_csum;
`else
    assign o_err_csum  = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader (frames, garbage, range, empty frame, mid-frame reset, checksum)
module tb_imem_loader;
    localparam int unsigned MEM_BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err_range;
    logic        err_csum;

    int          checks = 0;
    int          failures = 0;
    int          stalls;
    logic [63:0] exp_q[$];
    logic [7:0]  mem_model [logic [31:0]];
    logic [31:0] payload [0:7];
    logic        hold_after_sync;
    logic        erange_after_sync;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_hold  (cpu_hold),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_range (err_range),
        .o_err_csum  (err_csum)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return {mem_model[a], mem_model[a + 32'd1], mem_model[a + 32'd2], mem_model[a + 32'd3]};
    endfunction

    // advance one cycle and pop the scoreboard on any write strobe
    task automatic step();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%h data=%h required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write_value got addr=%h data=%h required addr=%h data=%h",
                             mem_addr, mem_wdata, e[63:32], e[31:0]);
                end
            end
            mem_model[mem_addr]         = mem_wdata[31:24];
            mem_model[mem_addr + 32'd1] = mem_wdata[23:16];
            mem_model[mem_addr + 32'd2] = mem_wdata[15:8];
            mem_model[mem_addr + 32'd3] = mem_wdata[7:0];
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            r = in_ready;
            step();
            if (r) acc = 1'b1;
            else stalls++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout byte=%h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [15:0] n, input logic [7:0] csum_delta);
        logic [7:0]  sum;
        logic [31:0] a;
        logic [31:0] w;
        sum = 8'd0;
        send_byte(8'hA5);
        hold_after_sync   = cpu_hold;
        erange_after_sync = err_range;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(base[31 - 8*i -: 8]);
            sum = sum + base[31 - 8*i -: 8];
        end
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        sum = sum + n[15:8] + n[7:0];
        for (int k = 0; k < int'(n); k++) begin
            w = payload[k];
            a = {base[31:2], 2'b00} + 32'(4 * k);
            if (({1'b0, a} + 33'd3) < 33'(MEM_BYTES)) exp_q.push_back({a, w});
            for (int j = 0; j < 4; j++) begin
                send_byte(w[31 - 8*j -: 8]);
                sum = sum + w[31 - 8*j -: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - sum) + csum_delta);
`else
        if (csum_delta != 8'd0) sum = sum + csum_delta;
`endif
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got done=%b in_ready=%b required done=1 in_ready=0", done, in_ready);
        end
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL back_to_back got stalls=%0d required 0", stalls);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        step();
        step();
        checks++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err_range, err_csum} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got %b required 1000000",
                     {in_ready, mem_we, cpu_hold, busy, done, err_range, err_csum});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h data=%h required 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        payload[0] = 32'hDEADBEEF;
        payload[1] = 32'h01020304;
        send_frame(32'h0000_0100, 16'd2, 8'd0);
        checks++;
        if (hold_after_sync !== 1'b1) begin
            failures++;
            $display("FAIL hold_after_sync got %b required 1", hold_after_sync);
        end
        checks++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release_after_done got hold=%b busy=%b required 0 0", cpu_hold, busy);
        end
        checks++;
        if (mem_read(32'h100) !== 32'hDEADBEEF || mem_read(32'h104) !== 32'h01020304) begin
            failures++;
            $display("FAIL mem_readback got %h %h required deadbeef 01020304", mem_read(32'h100), mem_read(32'h104));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_missing got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_garbage();
        send_byte(8'h00);
        send_byte(8'hFF);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL garbage_busy got %b required 0", busy);
        end
        payload[0] = 32'hCAFEF00D;
        send_frame(32'h0000_0203, 16'd1, 8'd0);
        checks++;
        if (mem_read(32'h200) !== 32'hCAFEF00D || exp_q.size() != 0) begin
            failures++;
            $display("FAIL garbage_write got %h pending=%0d required cafef00d pending=0", mem_read(32'h200), exp_q.size());
        end
    endtask

    task automatic test_range();
        payload[0] = 32'h11223344;
        payload[1] = 32'h55667788;
        send_frame(32'h0000_FFFC, 16'd2, 8'd0);
        checks++;
        if (err_range !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL range_err got err_range=%b pending=%0d required 1 0", err_range, exp_q.size());
        end
        send_frame(32'h0000_0040, 16'd0, 8'd0);
        checks++;
        if (erange_after_sync !== 1'b0 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL range_clear got at_sync=%b after=%b required 0 0", erange_after_sync, err_range);
        end
    endtask

    task automatic test_zero();
        send_frame(32'h0000_0080, 16'd0, 8'd0);
        checks++;
        if (hold_after_sync !== 1'b1 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL zero_hold got during=%b after=%b required 1 0", hold_after_sync, cpu_hold);
        end
    endtask

    task automatic test_mid_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b hold=%b we=%b required 0 0 0", busy, cpu_hold, mem_we);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins got busy=%b required 0", busy);
        end
        payload[0] = 32'h0A0B0C0D;
        send_frame(32'h0000_0300, 16'd1, 8'd0);
        checks++;
        if (mem_read(32'h300) !== 32'h0A0B0C0D || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset_frame got %h pending=%0d required 0a0b0c0d 0", mem_read(32'h300), exp_q.size());
        end
    endtask

    task automatic test_csum();
        payload[0] = 32'h12345678;
        send_frame(32'h0000_0400, 16'd1, 8'd0);
        checks++;
        if (err_csum !== 1'b0) begin
            failures++;
            $display("FAIL csum_good got err_csum=%b required 0", err_csum);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        payload[0] = 32'h9ABCDEF0;
        send_frame(32'h0000_0500, 16'd1, 8'd1);
        checks++;
        if (err_csum !== 1'b1 || mem_read(32'h500) !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL csum_bad got err_csum=%b mem=%h required 1 9abcdef0", err_csum, mem_read(32'h500));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_range();
        test_zero();
        test_mid_reset();
        test_csum();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream boot loader that fills the instruction memory before the core runs. It accepts framed bytes over a valid/ready handshake, packs them big-endian into 32-bit words, and issues word writes at incrementing byte addresses. The byte order matches the memory's read port (`{m[a], m[a+1], m[a+2], m[a+3]}`). It holds the CPU in reset while a frame is in flight and sits between the host link and the instruction memory write port.

## Interface
- `MEM_BYTES`, default 65536: instruction memory size in bytes; the writable range check uses it.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: the loader accepts a byte when `in_valid && in_ready`.
- `in_data` input 8: stream byte.
- `mem_we` output 1: one-cycle word-write strobe.
- `mem_addr` output 32: byte address of the word; always 4-aligned.
- `mem_wdata` output 32: word; `[31:24]` is stored at `mem_addr`, `[7:0]` at `mem_addr+3`.
- `cpu_hold` output 1: high while a frame is being loaded.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse at frame completion.
- `err_range` output 1: sticky; a write was suppressed because it fell out of range.
- `err_csum` output 1: sticky; checksum mismatch. Tied 0 without the macro.

## Operation
- Frame format: sync byte `0xA5`, then a 4-byte base address (MSB first), then a 2-byte word count N (MSB first), then 4N data bytes, then an optional checksum byte (see Configuration).
- FSM states: IDLE, ADDR, CNT, DATA, CSUM, DONE.
  - IDLE: discards any byte other than `0xA5`. Accepting `0xA5` clears `err_range`/`err_csum` and moves to ADDR.
  - ADDR: collects 4 bytes, then moves to CNT. `base[1:0]` is forced to 0.
  - CNT: collects 2 bytes. If N==0, moves to CSUM (macro) or DONE. Otherwise moves to DATA.
  - DATA: packs bytes. The 4th byte of word k produces a write at `base + 4k`. After word N-1, moves to CSUM or DONE.
  - CSUM: accepts one byte, compares it, then moves to DONE.
  - DONE: a single cycle with `in_ready`=0 and `done`=1, then returns to IDLE.
- `in_ready` = 1 in every state except DONE.
- Address arithmetic is 32-bit modulo 2^32. The word index counter is 16 bits.
- Range rule: if `mem_addr + 3 >= MEM_BYTES`, `mem_we` stays 0 and `err_range` is set. The frame continues to completion.
- `cpu_hold` goes high in the cycle after the sync byte is accepted and low in the cycle after DONE.
- A `0xA5` byte inside ADDR/CNT/DATA is ordinary payload, not a resync.

## Timing
- Reset values:
  - `in_ready`=1
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `cpu_hold`=0, `busy`=0, `done`=0
  - `err_range`=0, `err_csum`=0
  - state = IDLE
- Write latency: `mem_we` is asserted for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `mem_addr`/`mem_wdata` are registered and valid during that cycle.
- `done`: the cycle after the final frame byte (last data byte, checksum, or count byte when N==0) is accepted. The final `mem_we` and `done` are coincident.
- Back-to-back bytes on every cycle are sustained with no stalls except the DONE cycle.
- Gaps in `in_valid` are tolerated anywhere; state is held.
- Reset mid-frame: returns to IDLE next cycle. A partial word is discarded, no write is issued, and `cpu_hold` drops.
- `rst` and `in_valid` in the same cycle: reset wins and the byte is dropped.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A trailing checksum byte C follows the data. The required relation is 8-bit (sum of addr, count and data bytes + C) mod 256 == 0.
  - On mismatch, `err_csum` is set. Writes already issued are not undone.
- `IMEM_LOADER_CHECKSUM_EN` undefined:
  - The CSUM state and accumulator are removed, and the frame ends after the data bytes.
  - `err_csum` is constant 0.

## Structure
- Package `imem_loader_pkg`: `SYNC_BYTE` = 8'hA5, the state enum, and the frame field lengths (4, 2).
- Sub-module `imem_word_packer`: shifts in bytes MSB first and flags when a word is complete. It is cleared by `rst` and by frame start.

## Test plan
- Frame A5 00 00 01 00 00 02 DE AD BE EF 01 02 03 04 -> writes 0xDEADBEEF @0x100 then 0x01020304 @0x104. `done` is coincident with the 2nd write. Reading the memory at 0x100 returns 0xDEADBEEF.
- Leading garbage 00 FF, then frame with base 0x00000203 and N=1 -> garbage ignored; write lands @0x200, with `base[1:0]` masked.
- Base 0x0000FFFC, N=2 -> write @0xFFFC; the 2nd word is suppressed and `err_range`=1. `done` still pulses. The next sync clears `err_range`.
- N=0 frame -> no `mem_we`; `done` occurs 1 cycle after the count byte (or after the checksum byte with the macro); `cpu_hold` is high for the frame duration.
- Assert `rst` after 2 of the 4 bytes of word 0 -> no write, IDLE, `cpu_hold`=0. A following full frame loads correctly.
- With the macro: correct checksum -> `err_csum`=0; checksum off by 1 -> `err_csum`=1 and the writes are still present.
